// File: rtl/change_return_controller_if.sv
// ----------------------------------------------------------------------------
// change_return_controller_if
//
// Purpose: bundles the signals exchanged between the change-return controller
// and its environment (the next-total calculator and the coin/item front end).
//
// Signals:
//   i_input_coin      coins inserted this cycle, bit i = denomination i
//   o_output_item     items dispensed this cycle (driven by the calculator)
//   i_trigger_return  user return request, level, sampled every cycle
//   current_total     registered credit held by the calculator
//   wait_time         remaining idle cycles (registered)
//   o_return_coin     one-hot coin returned this cycle (combinational)
//   o_returning       high while the controller is returning change
//   o_return_cnt      per-denomination return counters, only when the
//                     VM_RETURN_STATS_EN macro is defined
//
// Modports:
//   master  environment side: drives coin/item/trigger/credit, observes outputs
//   slave   controller side
//
// Handshake: there is no valid/ready pair here. Every input is a level that
// is sampled on each rising clock edge; every output is valid continuously
// and is meaningful on every cycle.
// ----------------------------------------------------------------------------
interface change_return_controller_if #(
  parameter int K_NUM_COINS  = 3,
  parameter int K_NUM_ITEMS  = 4,
  parameter int K_TOTAL_BITS = 31
);

  logic [K_NUM_COINS-1:0]  i_input_coin;
  logic [K_NUM_ITEMS-1:0]  o_output_item;
  logic                    i_trigger_return;
  logic [K_TOTAL_BITS-1:0] current_total;
  logic [31:0]             wait_time;
  logic [K_NUM_COINS-1:0]  o_return_coin;
  logic                    o_returning;
`ifdef VM_RETURN_STATS_EN
  logic [K_NUM_COINS-1:0][15:0] o_return_cnt;
`endif

  modport master (
    output i_input_coin, o_output_item, i_trigger_return, current_total,
    input  wait_time, o_return_coin, o_returning
`ifdef VM_RETURN_STATS_EN
    , input o_return_cnt
`endif
  );

  modport slave (
    input  i_input_coin, o_output_item, i_trigger_return, current_total,
    output wait_time, o_return_coin, o_returning
`ifdef VM_RETURN_STATS_EN
    , output o_return_cnt
`endif
  );

endinterface

// File: rtl/change_return_controller.sv
// ----------------------------------------------------------------------------
// change_return_controller
//
// Purpose: sequential companion to the vending machine's next-total
// calculator. It owns the idle timeout counter (wait_time) and the
// change-return FSM. When the user asks for change, or the machine sits idle
// for K_WAIT_TIME cycles, it returns the credit greedily, one coin per cycle,
// by asserting o_return_coin; the calculator subtracts that coin from
// current_total on the same clock edge.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        change_return_controller_if.slave (coin/item/trigger/credit
//              in, wait_time/o_return_coin/o_returning out)
//   dbg_state  current FSM state encoding (0 IDLE, 1 ACTIVE, 2 RETURN)
//
// Optional feature: define VM_RETURN_STATS_EN to add per-denomination
// returned-coin counters on bus.o_return_cnt (16-bit, wrapping, cleared only
// by reset). Without the macro the counters do not exist and all other
// behaviour is unchanged.
//
// The denomination table holds exactly three coins, ordered smallest first.
// ----------------------------------------------------------------------------
module change_return_controller #(
  parameter int K_NUM_COINS  = 3,
  parameter int K_NUM_ITEMS  = 4,
  parameter int K_TOTAL_BITS = 31,
  parameter int K_WAIT_TIME  = 100,
  parameter int COIN0_VALUE  = 100,
  parameter int COIN1_VALUE  = 500,
  parameter int COIN2_VALUE  = 1000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  change_return_controller_if.slave  bus,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RETURN = 2'd2
  } state_t;

  localparam logic [31:0] WAIT_RELOAD = 32'(K_WAIT_TIME);

  // Denomination values at the credit width, smallest first.
  localparam logic [K_TOTAL_BITS-1:0] COIN_VALUE [3] = '{
    K_TOTAL_BITS'(COIN0_VALUE),
    K_TOTAL_BITS'(COIN1_VALUE),
    K_TOTAL_BITS'(COIN2_VALUE)
  };

  state_t                 state_q;
  state_t                 state_d;
  logic [31:0]            wait_q;
  logic [31:0]            wait_d;
  logic [K_NUM_COINS-1:0] coins_in;
  logic [K_NUM_ITEMS-1:0] items_out;
  logic                   coin_seen;
  logic                   reload;
  logic                   below_min;
  logic [K_NUM_COINS-1:0] return_coin;

  assign coins_in  = bus.i_input_coin;
  assign items_out = bus.o_output_item;
  assign coin_seen = |coins_in;
  // Any customer activity restarts the idle timer while ACTIVE.
  assign reload    = coin_seen | (|items_out);
  assign below_min = bus.current_total < COIN_VALUE[0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and timer
  //
  // In ACTIVE the priority is: return request, then reload, then timeout,
  // then plain decrement. The timeout fires on wait_time==1 so the timer
  // reads 0 on the same cycle the FSM enters RETURN.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (coin_seen) begin
          state_d = S_ACTIVE;
          wait_d  = WAIT_RELOAD;
        end
      end

      S_ACTIVE: begin
        if (bus.i_trigger_return) begin
          state_d = S_RETURN;
          wait_d  = '0;
        end else if (reload) begin
          wait_d  = WAIT_RELOAD;
        end else if (wait_q == 32'd1) begin
          state_d = S_RETURN;
          wait_d  = '0;
        end else if (wait_q != 32'd0) begin
          wait_d  = wait_q - 32'd1;
        end
      end

      S_RETURN: begin
        // Coins inserted or return requests here are ignored by the FSM;
        // inserted coins reach current_total upstream and get returned too.
        wait_d = '0;
        if (below_min) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Greedy coin selection: ascending scan, so the last denomination that fits
  // is the largest one. Only ever one bit set, and only in RETURN.
  // --------------------------------------------------------------------------
  always_comb begin
    return_coin = '0;
    if (state_q == S_RETURN) begin
      for (int i = 0; i < 3; i++) begin
        if (bus.current_total >= COIN_VALUE[i]) begin
          return_coin = K_NUM_COINS'(1) << i;
        end
      end
    end
  end

  assign bus.o_return_coin = return_coin;
  assign bus.o_returning   = (state_q == S_RETURN);
  assign bus.wait_time     = wait_q;
  assign dbg_state         = state_q;

`ifdef VM_RETURN_STATS_EN
  // --------------------------------------------------------------------------
  // Returned-coin statistics, one wrapping counter per denomination.
  // --------------------------------------------------------------------------
  logic [K_NUM_COINS-1:0][15:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < K_NUM_COINS; i++) begin
        if (return_coin[i]) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign bus.o_return_cnt = cnt_q;
`endif

endmodule
